ir_tx: RTL



---
 rtl/ir_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ir_tx.sv
// ir_tx: NEC-format infrared transmitter.
// Serialises a 32-bit custom+data word (MSB first) or an NEC repeat frame
// into mark/space timing. Outputs: the raw envelope, a carrier-modulated LED
// drive, and an inverted envelope that can be looped straight into the IR receiver.
module ir_tx #(
  parameter int TICK_DIV      = 50,
  parameter int CARRIER_DIV   = 1316,
  parameter int LEAD_MARK_US  = 9000,
  parameter int LEAD_SPACE_US = 4500,
  parameter int REP_SPACE_US  = 2250,
  parameter int BIT_MARK_US   = 560,
  parameter int ZERO_SPACE_US = 560,
  parameter int ONE_SPACE_US  = 1690,
  parameter int MOD_EN        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_repeat,
  input  logic [31:0] i_data,
  output logic        o_ir_tx,
  output logic        o_ir_env,
  output logic        o_ir_txb,
  output logic        o_busy,
  output logic        o_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_prescale;
  logic [15:0]     r_usCnt;
  logic [CW-1:0]   r_carrierCnt;
  logic [31:0]     r_shiftReg;
  logic [5:0]      r_bitCnt;
  logic            r_repeat;
  logic            r_env;
  logic            r_irTx;
  logic            r_busy;
  logic            r_done;

  logic [15:0]     w_phaseUs;
  logic            w_tickWrap;
  logic            w_phaseEnd;
  logic [CW-1:0]   w_carrierNext;
  logic            w_carrierGate;

  // Length in microseconds of the phase the FSM is currently in.
  always_comb begin
    w_phaseUs = 16'd1;
    case (r_state)
      LEAD_MARK:  w_phaseUs = 16'(LEAD_MARK_US);
      LEAD_SPACE: w_phaseUs = r_repeat ? 16'(REP_SPACE_US) : 16'(LEAD_SPACE_US);
      BIT_MARK:   w_phaseUs = 16'(BIT_MARK_US);
      BIT_SPACE:  w_phaseUs = r_shiftReg[31] ? 16'(ONE_SPACE_US) : 16'(ZERO_SPACE_US);
      STOP_MARK:  w_phaseUs = 16'(BIT_MARK_US);
      default:    w_phaseUs = 16'd1;
    endcase
  end

  // Phase end falls on the last clk of the last microsecond, so a phase of
  // N us occupies exactly N*TICK_DIV cycles; carrier gating looks one count ahead
  // because o_ir_tx is registered alongside the counter.
  always_comb begin
    w_tickWrap    = (r_prescale == PW'(TICK_DIV - 1));
    w_phaseEnd    = w_tickWrap && (r_usCnt == (w_phaseUs - 16'd1));
    w_carrierNext = (r_carrierCnt == CW'(CARRIER_DIV - 1)) ? '0 : r_carrierCnt + CW'(1);
    w_carrierGate = (MOD_EN == 0) || (w_carrierNext < CW'(CARRIER_DIV / 2));
  end

  // Frame sequencer: timers, shift register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prescale   <= '0;
      r_usCnt      <= '0;
      r_carrierCnt <= '0;
      r_shiftReg   <= '0;
      r_bitCnt     <= '0;
      r_repeat     <= 1'b0;
      r_env        <= 1'b0;
      r_irTx       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_carrierCnt <= w_carrierNext;
      r_irTx       <= r_env & w_carrierGate;
      if (w_tickWrap) begin
        r_prescale <= '0;
        r_usCnt    <= r_usCnt + 16'd1;
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end

      case (r_state)
        IDLE: begin
          r_prescale   <= '0;
          r_usCnt      <= '0;
          r_carrierCnt <= '0;
          r_env        <= 1'b0;
          r_irTx       <= 1'b0;
          r_busy       <= 1'b0;
          if (i_start || i_repeat) begin
            if (i_start) begin
              r_shiftReg <= i_data;
            end
            r_repeat <= ~i_start;
            r_bitCnt <= '0;
            r_state  <= LEAD_MARK;
            r_env    <= 1'b1;
            r_irTx   <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        LEAD_MARK: begin
          if (w_phaseEnd) begin
            r_state    <= LEAD_SPACE;
            r_prescale <= '0;
            r_usCnt    <= '0;
            r_env      <= 1'b0;
            r_irTx     <= 1'b0;
          end
        end

        LEAD_SPACE: begin
          if (w_phaseEnd) begin
            r_state      <= r_repeat ? STOP_MARK : BIT_MARK;
            r_prescale   <= '0;
            r_usCnt      <= '0;
            r_carrierCnt <= '0;
            r_env        <= 1'b1;
            r_irTx       <= 1'b1;
          end
        end

        BIT_MARK: begin
          if (w_phaseEnd) begin
            r_state    <= BIT_SPACE;
            r_prescale <= '0;
            r_usCnt    <= '0;
            r_env      <= 1'b0;
            r_irTx     <= 1'b0;
          end
        end

        BIT_SPACE: begin
          if (w_phaseEnd) begin
            r_shiftReg   <= {r_shiftReg[30:0], 1'b0};
            r_bitCnt     <= r_bitCnt + 6'd1;
            r_state      <= (r_bitCnt == 6'd31) ? STOP_MARK : BIT_MARK;
            r_prescale   <= '0;
            r_usCnt      <= '0;
            r_carrierCnt <= '0;
            r_env        <= 1'b1;
            r_irTx       <= 1'b1;
          end
        end

        STOP_MARK: begin
          if (w_phaseEnd) begin
            r_state    <= DONE;
            r_prescale <= '0;
            r_usCnt    <= '0;
            r_env      <= 1'b0;
            r_irTx     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end

        DONE: begin
          r_state      <= IDLE;
          r_prescale   <= '0;
          r_usCnt      <= '0;
          r_carrierCnt <= '0;
          r_env        <= 1'b0;
          r_irTx       <= 1'b0;
          r_busy       <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ir_tx  = r_irTx;
  assign o_ir_env = r_env;
  assign o_ir_txb = ~r_env;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
